// File: rtl/se_pkg.sv
// Shared definitions for the squeeze-excitation fully-connected MAC:
// Q-format defaults, accumulator width derivation and FSM state encoding.
package se_pkg;

  localparam int SE_INT_BITS  = 5;
  localparam int SE_FRAC_BITS = 9;

  // Headroom of 6 bits covers up to 64 accumulated products without wrap.
  function automatic int acc_width(input int data_width, input int frac_bits);
    return 2 * data_width - frac_bits + 6;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } fc_state_e;

endpackage

// File: rtl/se_fc_mac_if.sv
// Bundle of control, input-stream, weight/bias memory and result signals
// for se_fc_mac; the MAC core sits on the slave modport.
interface se_fc_mac_if
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = SE_INT_BITS + SE_FRAC_BITS,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, SE_FRAC_BITS),
  parameter int W_AW       = 6,
  parameter int B_AW       = 2
);

  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         x_valid;
  logic                         x_ready;
  logic signed [DATA_WIDTH-1:0] x_data;
  logic        [W_AW-1:0]       w_addr;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic        [B_AW-1:0]       b_addr;
  logic signed [DATA_WIDTH-1:0] b_data;
  logic signed [ACC_WIDTH-1:0]  acc_out;
  logic                         acc_valid;

  modport master (
    output start, x_valid, x_data, w_data, b_data,
    input  busy, done, x_ready, w_addr, b_addr, acc_out, acc_valid
  );

  modport slave (
    input  start, x_valid, x_data, w_data, b_data,
    output busy, done, x_ready, w_addr, b_addr, acc_out, acc_valid
  );

endinterface

// File: rtl/se_fc_mul.sv
// Registered signed multiply with fractional rescale (1-cycle latency).
// Build macro SE_FC_ROUND_EN selects round-half-up instead of floor.
module se_fc_mul #(
  parameter int DATA_WIDTH = 14,
  parameter int FRAC_BITS  = 9,
  parameter int ACC_WIDTH  = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  p_q
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam int XW = (PW > ACC_WIDTH) ? PW : ACC_WIDTH;

`ifdef SE_FC_ROUND_EN
  localparam logic signed [XW-1:0] RND = XW'(2 ** (FRAC_BITS - 1));
`endif

  logic signed [XW-1:0]        a_x;
  logic signed [XW-1:0]        b_x;
  logic signed [XW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] p_d;

  // Operands widened first so the low XW bits hold the exact product.
  always_comb begin
    a_x  = {{(XW - DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
    b_x  = {{(XW - DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
    prod = a_x * b_x;
`ifdef SE_FC_ROUND_EN
    prod = prod + RND;
`endif
    p_d  = ACC_WIDTH'(prod >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

endmodule

// File: rtl/se_fc_mac.sv
// Fully-connected layer MAC: buffers N_IN inputs, then streams N_IN*N_OUT
// weights at one per cycle and emits one accumulated sum per neuron.
//
// state      | meaning
// IDLE       | waiting for start
// LOAD       | accepting x_data into the input buffer
// COMPUTE    | issuing one weight address per cycle
// DRAIN      | letting the 3-stage pipeline empty, leave on done
module se_fc_mac
  import se_pkg::*;
#(
  parameter int INT_BITS   = SE_INT_BITS,
  parameter int FRAC_BITS  = SE_FRAC_BITS,
  parameter int DATA_WIDTH = INT_BITS + FRAC_BITS,
  parameter int N_IN       = 16,
  parameter int N_OUT      = 4
) (
  input logic        clk,
  input logic        rst_n,
  se_fc_mac_if.slave fc
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, FRAC_BITS);
  localparam int N_W       = N_IN * N_OUT;
  localparam int AW        = clog2_min1(N_W);
  localparam int BW        = clog2_min1(N_OUT);
  localparam int IW        = clog2_min1(N_IN);

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [BW-1:0] J_LAST = BW'(N_OUT - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N_W - 1);

  fc_state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [BW-1:0] j_q, j_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          issue;

  logic signed [DATA_WIDTH-1:0] xbuf_q [N_IN];
  logic signed [DATA_WIDTH-1:0] xbuf_d [N_IN];

  logic          s1_v_q, s1_v_d;
  logic [IW-1:0] s1_i_q, s1_i_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_lastn_q, s1_lastn_d;

  logic          s2_v_q, s2_v_d;
  logic          s2_first_q, s2_first_d;
  logic          s2_last_q, s2_last_d;
  logic          s2_lastn_q, s2_lastn_d;
  logic signed [DATA_WIDTH-1:0] bias_q, bias_d;

  logic signed [ACC_WIDTH-1:0] prod_q;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                        acc_valid_q, acc_valid_d;
  logic                        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    w_addr_d = w_addr_q;
    issue    = 1'b0;
    xbuf_d   = xbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (fc.start) begin
          state_d = ST_LOAD;
          i_d     = '0;
        end
      end
      ST_LOAD: begin
        if (fc.x_valid) begin
          xbuf_d[i_q] = fc.x_data;
          if (i_q == I_LAST) begin
            i_d      = '0;
            j_d      = '0;
            w_addr_d = '0;
            state_d  = ST_COMPUTE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        issue = 1'b1;
        if (w_addr_q != A_LAST) w_addr_d = w_addr_q + 1'b1;
        if (i_q == I_LAST) begin
          i_d = '0;
          if (j_q == J_LAST) state_d = ST_DRAIN;
          else               j_d     = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1 tracks the address cycle; stage 2 lines up with the product register.
  always_comb begin
    s1_v_d     = issue;
    s1_i_d     = i_q;
    s1_first_d = issue && (i_q == '0);
    s1_last_d  = issue && (i_q == I_LAST);
    s1_lastn_d = issue && (i_q == I_LAST) && (j_q == J_LAST);

    s2_v_d     = s1_v_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    s2_lastn_d = s1_lastn_q;
    bias_d     = s1_first_q ? fc.b_data : bias_q;

    bias_ext    = {{(ACC_WIDTH - DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    sum         = (s2_first_q ? bias_ext : acc_q) + prod_q;
    acc_d       = s2_v_q ? sum : acc_q;
    acc_out_d   = (s2_v_q && s2_last_q) ? sum : acc_out_q;
    acc_valid_d = s2_v_q && s2_last_q;
    done_d      = s2_v_q && s2_lastn_q;
  end

  se_fc_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (xbuf_q[s1_i_q]),
    .b     (fc.w_data),
    .p_q   (prod_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      w_addr_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_i_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_lastn_q  <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_lastn_q  <= 1'b0;
      bias_q      <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      w_addr_q    <= w_addr_d;
      s1_v_q      <= s1_v_d;
      s1_i_q      <= s1_i_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_lastn_q  <= s1_lastn_d;
      s2_v_q      <= s2_v_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_lastn_q  <= s2_lastn_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      done_q      <= done_d;
    end
  end

  // Input buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    xbuf_q <= xbuf_d;
  end

  assign fc.busy      = (state_q != ST_IDLE);
  assign fc.x_ready   = (state_q == ST_LOAD);
  assign fc.w_addr    = w_addr_q;
  assign fc.b_addr    = j_q;
  assign fc.acc_out   = acc_out_q;
  assign fc.acc_valid = acc_valid_q;
  assign fc.done      = done_q;

endmodule

// File: tb/tb_se_fc_mac.sv
// Scoreboard bench for se_fc_mac at N_IN=4, N_OUT=2, Q5.9 (1.0 = 512).
module tb_se_fc_mac;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 14;
  localparam int FB    = 9;
  localparam int ACCW  = 25;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  se_fc_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .W_AW(3), .B_AW(1)) fc();

  se_fc_mac #(
    .INT_BITS  (5),
    .FRAC_BITS (FB),
    .N_IN      (N_IN),
    .N_OUT     (N_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (fc)
  );

  logic signed [DW-1:0] wmem [N_IN*N_OUT];
  logic signed [DW-1:0] bmem [N_OUT];
  logic signed [DW-1:0] xv   [N_IN];

  always @(posedge clk) begin
    fc.w_data <= wmem[fc.w_addr];
    fc.b_data <= bmem[fc.b_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_cmp   = 0;
  int     n_bad   = 0;
  int     n_valid = 0;
  longint last_exp = 0;

  typedef struct {
    longint val;
    int     cyc;
    bit     last;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_neuron(input int j);
    longint s;
    longint p;
    s = longint'(bmem[j]);
    for (int i = 0; i < N_IN; i++) begin
      p = longint'(xv[i]) * longint'(wmem[j*N_IN + i]);
`ifdef SE_FC_ROUND_EN
      p = p + (64'sd1 <<< (FB - 1));
`endif
      s = s + (p >>> FB);
    end
    return s;
  endfunction

  task automatic fill(input int xval, input int wval, input int bval);
    for (int i = 0; i < N_IN; i++) xv[i] = DW'(xval);
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = DW'(wval);
    for (int j = 0; j < N_OUT; j++) bmem[j] = DW'(bval);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_IN; i++) xv[i] = DW'(int'($urandom_range(4095)) - 2048);
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = DW'(int'($urandom_range(4095)) - 2048);
    for (int j = 0; j < N_OUT; j++) bmem[j] = DW'(int'($urandom_range(2047)) - 1024);
  endtask

  // Called at a negedge with the DUT in LOAD; returns the cycle of address 0.
  task automatic load_x(input bit gap, input bit poke, output int l);
    for (int k = 0; k < N_IN; k++) begin
      if (gap && k == 2) begin
        fc.x_valid = 1'b0;
        fc.x_data  = '0;
        @(negedge clk);
        check_eq("ready_gap", fc.x_ready, 1);
      end
      fc.x_valid = 1'b1;
      fc.x_data  = xv[k];
      fc.start   = poke && (k == 1);
      @(negedge clk);
    end
    fc.x_valid = 1'b0;
    fc.start   = 1'b0;
    l = cyc;
  endtask

  task automatic run_pass(input string name, input bit gap, input bit poke);
    int     l;
    bit     seen;
    longint ev [N_OUT];
    for (int j = 0; j < N_OUT; j++) ev[j] = model_neuron(j);
    n_valid = 0;
    @(negedge clk);
    fc.start = 1'b1;
    @(negedge clk);
    fc.start = 1'b0;
    check_eq({name, "_busy"}, fc.busy, 1);
    check_eq({name, "_ready"}, fc.x_ready, 1);
    load_x(gap, poke, l);
    for (int j = 0; j < N_OUT; j++)
      sb.push_back('{ev[j], l + j*N_IN + N_IN + 2, (j == N_OUT-1)});
    if (poke) begin
      fc.start = 1'b1;
      @(negedge clk);
      fc.start = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = fc.done;
    end
    check_eq({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    check_eq({name, "_busy_end"}, fc.busy, 0);
    check_eq({name, "_n_valid"}, n_valid, N_OUT);
    check_eq({name, "_sb_left"}, sb.size(), 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      check_eq({name, "_no_restart"}, fc.busy, 0);
    end
    last_exp = ev[N_OUT-1];
    sb.delete();
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (fc.acc_valid || fc.done)) begin
      if (!fc.acc_valid) begin
        check_eq("done_alone", fc.acc_valid, 1);
      end else if (sb.size() == 0) begin
        check_eq("acc_unexpected", fc.acc_valid, 0);
      end else begin
        e = sb.pop_front();
        n_valid++;
        check_eq("acc_out", fc.acc_out, e.val);
        check_eq("acc_latency", cyc, e.cyc);
        check_eq("done_with_last", fc.done, longint'(e.last));
      end
    end
  end

  initial begin
    int l;
    rst_n      = 1'b0;
    fc.start   = 1'b0;
    fc.x_valid = 1'b0;
    fc.x_data  = '0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", fc.busy, 0);
    check_eq("rst_ready", fc.x_ready, 0);
    check_eq("rst_valid", fc.acc_valid, 0);
    check_eq("rst_done", fc.done, 0);
    check_eq("rst_acc", fc.acc_out, 0);
    check_eq("rst_waddr", fc.w_addr, 0);
    check_eq("rst_baddr", fc.b_addr, 0);

    // x_valid while idle must not start anything
    fc.x_valid = 1'b1;
    fc.x_data  = 14'sd123;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_ready", fc.x_ready, 0);
      check_eq("idle_busy", fc.busy, 0);
    end
    fc.x_valid = 1'b0;

    fill(512, 256, 0);
    run_pass("unit", 1'b1, 1'b0);
    check_eq("unit_value", last_exp, 1024);

    fill(512, -512, 128);
    run_pass("neg", 1'b0, 1'b0);
    check_eq("neg_value", last_exp, -1920);

    fill(-8192, -8192, 0);
    run_pass("max", 1'b0, 1'b0);
    check_eq("max_value", last_exp, 524288);

    fill(1, 256, 0);
    run_pass("rnd", 1'b0, 1'b0);

    fill_rand();
    run_pass("mix", 1'b1, 1'b1);

    // Reset in the middle of COMPUTE
    fill(512, 256, 0);
    @(negedge clk);
    fc.start = 1'b1;
    @(negedge clk);
    fc.start = 1'b0;
    load_x(1'b0, 1'b0, l);
    repeat (2) @(negedge clk);
    check_eq("mid_waddr", fc.w_addr, 2);
    check_eq("mid_baddr", fc.b_addr, 0);
    check_eq("acc_hold", fc.acc_out, last_exp);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", fc.busy, 0);
    check_eq("arst_ready", fc.x_ready, 0);
    check_eq("arst_valid", fc.acc_valid, 0);
    check_eq("arst_done", fc.done, 0);
    check_eq("arst_acc", fc.acc_out, 0);
    check_eq("arst_waddr", fc.w_addr, 0);
    check_eq("arst_baddr", fc.b_addr, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass("after_rst", 1'b0, 1'b0);
    check_eq("after_rst_value", last_exp, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
